mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Registered arbiter sharing the single axi_interface memory port between the i_cache
//  refill port and the d_cache miss/uncached port. Replaces the combinational miss-based
//  mux. Locks the grant for a whole transaction, captures request fields at grant, and
//  prevents instruction starvation under data-miss bursts.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive D grants allowed while I waits; next grant forced to I (>=1)
//  CNT_W         32 width of statistics counters (ARB_STATS_EN only)
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  i_strobe     in   1   I-side request; held until i_ready
//  i_addr       in   32  I-side physical address (word aligned)
//  i_ready      out  1   one-cycle pulse: I transaction done, m_data valid
//  d_strobe     in   1   D-side request; held until d_ready
//  d_addr       in   32  D-side physical address
//  d_rw         in   1   0 read, 1 write
//  d_size       in   2   00 byte, 01 half, 10 word
//  d_sel        in   4   byte strobes
//  d_wdata      in   32  write data
//  d_ready      out  1   one-cycle pulse: D transaction done
//  m_addr       out  32  to axi_interface mem_a
//  m_access     out  1   to mem_access
//  m_write      out  1   to mem_write
//  m_size       out  2   to mem_size
//  m_sel        out  4   to mem_sel
//  m_st_data    out  32  to mem_st_data
//  m_ready      in   1   from mem_ready, one-cycle completion pulse
//  grant_i      out  1   1 while I owns the port (debug)
//  grant_d      out  1   1 while D owns the port (debug)
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-transaction): state IDLE, all outputs 0, streak=0.
//  - States: IDLE, GNT_I, GNT_D, RELEASE.
//  - IDLE: no strobe -> IDLE. Only one strobe -> grant it. Both -> D, unless
//    streak==STARVE_LIMIT, then I. On grant, register addr/rw/size/sel/wdata into
//    m_* (I: m_write=0, m_size=10, m_sel=1111, m_st_data=0); m_access=1 next cycle.
//  - Latency: strobe in cycle N (port idle) -> m_access=1 in cycle N+1.
//  - GNT_x: m_* held constant until m_ready, independent of the requester strobe
//    (dropped strobe e.g. flush does not abort the AXI transfer). On m_ready:
//    x_ready=1 same cycle (combinational from m_ready & grant), m_access=0 next cycle,
//    go RELEASE. m_ready outside GNT_x ignored.
//  - RELEASE: one idle cycle so axi_interface sees access low; -> IDLE. Back-to-back
//    grant period therefore >= transaction + 2 cycles.
//  - streak: +1 on D grant while i_strobe=1 (saturate at STARVE_LIMIT); cleared on any
//    I grant or when D granted with i_strobe=0.
//  - grant_i/grant_d one-hot or zero; never both.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_i_grants, stat_d_grants, stat_i_wait
//   (cycles i_strobe=1 without grant_i), each CNT_W, wrap on overflow, reset 0,
//   plus input stat_clr (sync clear, priority over increment).
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  - mem_arb_pkg: state enum (IDLE/GNT_I/GNT_D/RELEASE), SIZE_BYTE/HALF/WORD constants,
//    SEL_ALL=4'b1111.
//  - Sub-module mem_arb_stats (counter bank), instantiated only under ARB_STATS_EN.
// TESTING
//  1 Lone I: i_strobe, i_addr=0xBFC00000 -> cycle+1 m_access=1, m_addr=0xBFC00000,
//    m_size=10, m_sel=1111; m_ready pulse -> i_ready=1 same cycle, d_ready=0.
//  2 Simultaneous I+D, streak=0 -> D first (d_addr, d_rw=1, d_sel=0011, d_wdata
//    0x12345678 on m_*); after d_ready+RELEASE, I granted.
//  3 STARVE_LIMIT=4, D strobe continuous, I waiting -> grants D,D,D,D,I; streak=0 after.
//  4 Change d_addr/d_wdata mid-grant, drop d_strobe -> m_* unchanged, m_access stays 1
//    until m_ready; d_ready still pulses.
//  5 Assert rst during GNT_D with m_access=1 -> m_access=0, grants 0 immediately;
//    stray m_ready after reset -> no ready pulse.
//  6 ARB_STATS_EN: scenario 3 -> stat_d_grants=4, stat_i_grants=1, stat_i_wait equals
//    counted wait cycles; stat_clr -> all 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory-port arbiter:
//   arb_state_t : arbiter FSM states (IDLE / GNT_I / GNT_D / RELEASE)
//   SIZE_*      : m_size encodings (byte / half / word)
//   SEL_ALL     : all four byte strobes
//   ADDR_W/DATA_W : memory port address and data widths
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_I   = 2'd1,
      GNT_D   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [3:0] SEL_ALL = 4'b1111;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_stats.sv
// -----------------------------------------------------------------------------
// mem_arb_stats
// Statistics counter bank for the memory-port arbiter. Counters wrap on
// overflow; stat_clr clears all three synchronously and wins over increments.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stat_clr        synchronous clear of all counters
//   i_grant_evt     one-cycle event: I side granted this cycle
//   d_grant_evt     one-cycle event: D side granted this cycle
//   i_wait_evt      I side requesting but not owning the port this cycle
//   stat_i_grants   count of I grants
//   stat_d_grants   count of D grants
//   stat_i_wait     count of I wait cycles
// -----------------------------------------------------------------------------
module mem_arb_stats
   import mem_arb_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stat_clr,
   input  logic             i_grant_evt,
   input  logic             d_grant_evt,
   input  logic             i_wait_evt,
   output logic [CNT_W-1:0] stat_i_grants,
   output logic [CNT_W-1:0] stat_d_grants,
   output logic [CNT_W-1:0] stat_i_wait
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_i_grants <= '0;
         stat_d_grants <= '0;
         stat_i_wait   <= '0;
      end else if (stat_clr) begin
         stat_i_grants <= '0;
         stat_d_grants <= '0;
         stat_i_wait   <= '0;
      end else begin
         if (i_grant_evt) stat_i_grants <= stat_i_grants + 1'b1;
         if (d_grant_evt) stat_d_grants <= stat_d_grants + 1'b1;
         if (i_wait_evt)  stat_i_wait   <= stat_i_wait + 1'b1;
      end
   end

endmodule : mem_arb_stats

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Registered arbiter sharing one memory port between the I-cache refill side
// and the D-cache miss/uncached side. A grant is locked for the whole
// transaction: request fields are captured at grant and held until m_ready,
// regardless of what the requester does afterwards. One RELEASE cycle follows
// every transaction so the downstream port sees m_access low between
// transfers. D wins ties, except after STARVE_LIMIT consecutive D grants with
// I waiting, when I is forced through.
//
// Optional feature: define ARB_STATS_EN to add stat_clr input and the
// stat_i_grants / stat_d_grants / stat_i_wait counter outputs.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_strobe, i_addr          I request (held until i_ready)
//   i_ready                   I done pulse (combinational from m_ready)
//   d_strobe, d_addr, d_rw,
//   d_size, d_sel, d_wdata    D request (held until d_ready)
//   d_ready                   D done pulse (combinational from m_ready)
//   m_addr, m_access, m_write,
//   m_size, m_sel, m_st_data  registered memory-port request
//   m_ready                   memory completion pulse
//   grant_i, grant_d          current owner (debug), never both
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_strobe,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   input  logic              d_strobe,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_rw,
   input  logic [1:0]        d_size,
   input  logic [3:0]        d_sel,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_access,
   output logic              m_write,
   output logic [1:0]        m_size,
   output logic [3:0]        m_sel,
   output logic [DATA_W-1:0] m_st_data,
   input  logic              m_ready,
   output logic              grant_i,
   output logic              grant_d
`ifdef ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  stat_i_grants,
   output logic [CNT_W-1:0]  stat_d_grants,
   output logic [CNT_W-1:0]  stat_i_wait
`endif
);

   localparam int STRK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIMIT);

   arb_state_t        state;
   logic [STRK_W-1:0] streak;

   logic starved;
   logic pick_d;
   logic pick_i;

   // D wins a tie unless I has already waited through STARVE_LIMIT D grants.
   always_comb begin
      starved = (streak == STRK_MAX);
      pick_d  = d_strobe && (!i_strobe || !starved);
      pick_i  = i_strobe && !pick_d;
   end

   // Completion is reported to the owner in the same cycle m_ready arrives;
   // grant_* are zero outside GNT_x so stray m_ready pulses are ignored.
   assign i_ready = m_ready & grant_i;
   assign d_ready = m_ready & grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         m_addr    <= '0;
         m_access  <= 1'b0;
         m_write   <= 1'b0;
         m_size    <= '0;
         m_sel     <= '0;
         m_st_data <= '0;
         grant_i   <= 1'b0;
         grant_d   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state     <= GNT_D;
                  m_addr    <= d_addr;
                  m_access  <= 1'b1;
                  m_write   <= d_rw;
                  m_size    <= d_size;
                  m_sel     <= d_sel;
                  m_st_data <= d_wdata;
                  grant_d   <= 1'b1;
                  // The streak only measures D grants taken while I waits.
                  if (i_strobe)
                     streak <= starved ? streak : streak + 1'b1;
                  else
                     streak <= '0;
               end else if (pick_i) begin
                  state     <= GNT_I;
                  m_addr    <= i_addr;
                  m_access  <= 1'b1;
                  m_write   <= 1'b0;
                  m_size    <= SIZE_WORD;
                  m_sel     <= SEL_ALL;
                  m_st_data <= '0;
                  grant_i   <= 1'b1;
                  streak    <= '0;
               end
            end
            // Fields stay frozen until completion; a dropped strobe (e.g. a
            // cache flush) cannot abort a transfer already on the bus.
            GNT_I, GNT_D: begin
               if (m_ready) begin
                  state    <= RELEASE;
                  m_access <= 1'b0;
                  grant_i  <= 1'b0;
                  grant_d  <= 1'b0;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic i_grant_evt;
   logic d_grant_evt;
   logic i_wait_evt;

   always_comb begin
      i_grant_evt = (state == IDLE) && pick_i;
      d_grant_evt = (state == IDLE) && pick_d;
      i_wait_evt  = i_strobe && !grant_i;
   end

   mem_arb_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk           (clk),
      .rst           (rst),
      .stat_clr      (stat_clr),
      .i_grant_evt   (i_grant_evt),
      .d_grant_evt   (d_grant_evt),
      .i_wait_evt    (i_wait_evt),
      .stat_i_grants (stat_i_grants),
      .stat_d_grants (stat_d_grants),
      .stat_i_wait   (stat_i_wait)
   );
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios drive requests and a simple memory responder; expected
// transactions are queued at issue and a monitor pops and compares them when
// the memory completes (m_access & m_ready).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_strobe = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ready;
   logic        d_strobe = 1'b0;
   logic [31:0] d_addr = '0;
   logic        d_rw = 1'b0;
   logic [1:0]  d_size = '0;
   logic [3:0]  d_sel = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ready;
   logic [31:0] m_addr;
   logic        m_access;
   logic        m_write;
   logic [1:0]  m_size;
   logic [3:0]  m_sel;
   logic [31:0] m_st_data;
   logic        m_ready = 1'b0;
   logic        grant_i;
   logic        grant_d;
`ifdef ARB_STATS_EN
   logic             stat_clr = 1'b0;
   logic [CNT_W-1:0] stat_i_grants;
   logic [CNT_W-1:0] stat_d_grants;
   logic [CNT_W-1:0] stat_i_wait;
`endif

   mem_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_strobe  (i_strobe),
      .i_addr    (i_addr),
      .i_ready   (i_ready),
      .d_strobe  (d_strobe),
      .d_addr    (d_addr),
      .d_rw      (d_rw),
      .d_size    (d_size),
      .d_sel     (d_sel),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .m_addr    (m_addr),
      .m_access  (m_access),
      .m_write   (m_write),
      .m_size    (m_size),
      .m_sel     (m_sel),
      .m_st_data (m_st_data),
      .m_ready   (m_ready),
      .grant_i   (grant_i),
      .grant_d   (grant_d)
`ifdef ARB_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_i_grants (stat_i_grants),
      .stat_d_grants (stat_d_grants),
      .stat_i_wait   (stat_i_wait)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_i;
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic push(input bit is_i, input logic [31:0] addr, input logic wr,
                       input logic [1:0] size, input logic [3:0] sel, input logic [31:0] wdata);
      exp_t e;
      e.is_i = is_i; e.addr = addr; e.wr = wr; e.size = size; e.sel = sel; e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: wait for m_access, hold it lat cycles, then pulse m_ready.
   task automatic serve(input int lat);
      int n;
      n = 0;
      while (!m_access && n < 20) begin
         cyc();
         n++;
      end
      if (!m_access) begin
         checks++;
         errors++;
         $display("FAIL serve_timeout: m_access=0 expected 1 within 20 cycles");
      end else begin
         repeat (lat) cyc();
         m_ready = 1'b1;
         cyc();
         m_ready = 1'b0;
      end
   endtask

   // Monitor: compare each completed transaction against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (grant_i || grant_d) check("grant_onehot", {31'd0, grant_i & grant_d}, 32'd0);
         if (m_ready && m_access) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_txn: addr=0x%08h with empty scoreboard", m_addr);
            end else begin
               mon_e = exp_q.pop_front();
               check("txn_grant_i", {31'd0, grant_i}, {31'd0, mon_e.is_i});
               check("txn_grant_d", {31'd0, grant_d}, {31'd0, !mon_e.is_i});
               check("txn_addr",    m_addr, mon_e.addr);
               check("txn_write",   {31'd0, m_write}, {31'd0, mon_e.wr});
               check("txn_size",    {30'd0, m_size}, {30'd0, mon_e.size});
               check("txn_sel",     {28'd0, m_sel}, {28'd0, mon_e.sel});
               check("txn_st_data", m_st_data, mon_e.wdata);
               check("txn_i_ready", {31'd0, i_ready}, {31'd0, mon_e.is_i});
               check("txn_d_ready", {31'd0, d_ready}, {31'd0, !mon_e.is_i});
            end
         end else if (m_ready) begin
            check("stray_i_ready", {31'd0, i_ready}, 32'd0);
            check("stray_d_ready", {31'd0, d_ready}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) cyc();
      check("rst_m_access", {31'd0, m_access}, 32'd0);
      check("rst_grants",   {30'd0, grant_i, grant_d}, 32'd0);
      check("rst_m_addr",   m_addr, 32'd0);
      rst = 1'b0;
      cyc();

      // 1: lone I request, one-cycle latency to m_access
      i_strobe = 1'b1; i_addr = 32'hBFC0_0000;
      push(1'b1, 32'hBFC0_0000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      cyc();
      check("lat_m_access", {31'd0, m_access}, 32'd1);
      check("lat_grant_i",  {31'd0, grant_i}, 32'd1);
      serve(1);
      i_strobe = 1'b0;
      cyc();

      // 2: simultaneous I and D with empty streak: D first, then I
      i_strobe = 1'b1; i_addr = 32'h0000_1000;
      d_strobe = 1'b1; d_addr = 32'h8000_0040; d_rw = 1'b1;
      d_size = SIZE_HALF; d_sel = 4'b0011; d_wdata = 32'h1234_5678;
      push(1'b0, 32'h8000_0040, 1'b1, SIZE_HALF, 4'b0011, 32'h1234_5678);
      push(1'b1, 32'h0000_1000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      cyc();
      check("tie_grant_d", {31'd0, grant_d}, 32'd1);
      serve(0);
      d_strobe = 1'b0;
      serve(2);
      i_strobe = 1'b0;
      cyc();

`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
`endif

      // 3: continuous D with I waiting -> D,D,D,D,I
      d_strobe = 1'b1; d_addr = 32'h0000_2000; d_rw = 1'b0;
      d_size = SIZE_WORD; d_sel = SEL_ALL; d_wdata = 32'd0;
      i_strobe = 1'b1; i_addr = 32'h0000_3000;
      for (int k = 0; k < STARVE_LIMIT; k++)
         push(1'b0, 32'h0000_2000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      push(1'b1, 32'h0000_3000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      for (int k = 0; k <= STARVE_LIMIT; k++) serve(1);
      i_strobe = 1'b0;
      d_strobe = 1'b0;
      cyc();

`ifdef ARB_STATS_EN
      check("stat_d_grants", stat_d_grants, 32'd4);
      check("stat_i_grants", stat_i_grants, 32'd1);
      check("stat_i_wait",   stat_i_wait,   32'd17);
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      check("stat_clr_d", stat_d_grants, 32'd0);
      check("stat_clr_i", stat_i_grants, 32'd0);
      check("stat_clr_w", stat_i_wait,   32'd0);
`endif

      // streak cleared by the I grant: a new tie goes to D again
      i_strobe = 1'b1; i_addr = 32'h0000_4000;
      d_strobe = 1'b1; d_addr = 32'h0000_5000;
      push(1'b0, 32'h0000_5000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      push(1'b1, 32'h0000_4000, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      serve(0);
      d_strobe = 1'b0;
      serve(0);
      i_strobe = 1'b0;
      cyc();

      // 4: request changes and strobe drop mid-grant do not disturb m_*
      d_strobe = 1'b1; d_addr = 32'h0000_0040; d_rw = 1'b1;
      d_size = SIZE_WORD; d_sel = SEL_ALL; d_wdata = 32'hCAFE_F00D;
      push(1'b0, 32'h0000_0040, 1'b1, SIZE_WORD, SEL_ALL, 32'hCAFE_F00D);
      cyc();
      d_addr = 32'hDEAD_0000; d_wdata = 32'h0; d_strobe = 1'b0; d_rw = 1'b0;
      repeat (3) cyc();
      check("hold_m_access", {31'd0, m_access}, 32'd1);
      check("hold_m_addr",   m_addr, 32'h0000_0040);
      serve(0);
      cyc();

      // 5: async reset during GNT_D, then stray m_ready
      d_strobe = 1'b1; d_addr = 32'h0000_0080; d_rw = 1'b1; d_wdata = 32'h5555_AAAA;
      cyc();
      check("pre_rst_access", {31'd0, m_access}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_access", {31'd0, m_access}, 32'd0);
      check("async_rst_grants", {30'd0, grant_i, grant_d}, 32'd0);
      d_strobe = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      m_ready = 1'b1;
      #1;
      check("stray_ready_pair", {30'd0, i_ready, d_ready}, 32'd0);
      cyc();
      m_ready = 1'b0;
      cyc();

      // port still usable after reset
      i_strobe = 1'b1; i_addr = 32'h0000_0100;
      push(1'b1, 32'h0000_0100, 1'b0, SIZE_WORD, SEL_ALL, 32'd0);
      serve(1);
      i_strobe = 1'b0;
      repeat (3) cyc();

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_port_arbiter
